text_console_writer: RTL and testbench

Writer side of the text-mode VGA path. It accepts a stream of ASCII keystrokes and turns them into character-cell writes for the 70×30 text buffer that the VGA scan-out reads. It keeps the cursor, handles control codes (newline, carriage return, backspace, form feed) and does hardware scrolling through a top-row offset. Scrolled-in lines and the whole screen are cleared by a local fill engine.

---
 rtl/text_console_if.sv | 26 ++
 rtl/text_console_writer.sv | 214 +++++++++++++++++++++
 tb/tb_text_console_writer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_if.sv
// Key stream in, character-cell writes and cursor/scroll status out, for the text console writer.
interface text_console_if;
  logic        key_valid;
  logic        key_ready;
  logic [7:0]  key_data;
  logic [2:0]  key_color;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [10:0] wr_data;
  logic [4:0]  scroll_row;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;

  // Key source and buffer/status consumer side.
  modport master (
    output key_valid, key_data, key_color,
    input  key_ready, wr_en, wr_addr, wr_data, scroll_row, cur_row, cur_col, busy
  );

  // Console writer side.
  modport slave (
    input  key_valid, key_data, key_color,
    output key_ready, wr_en, wr_addr, wr_data, scroll_row, cur_row, cur_col, busy
  );
endinterface

// File: rtl/text_console_writer.sv
// Turns ASCII keystrokes into 70x30 text-buffer cell writes with cursor, control codes and hardware scroll.
// Optional: define CONSOLE_TAB_EN to make 0x09 advance to the next multiple-of-8 column.
module text_console_writer #(
  parameter int unsigned COLS  = 70,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input logic           clk,
  input logic           reset,
  text_console_if.slave con_if
);

  localparam int unsigned COL_W = 7;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned SUM_W = ROW_W + 1;
  localparam int unsigned CLR_W = 3;
  localparam int unsigned ADR_W = ROW_W + COL_W;
  localparam int unsigned DAT_W = CLR_W + 8;
`ifdef CONSOLE_TAB_EN
  localparam int unsigned TAB_W = COL_W + 1;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   fill_row_q, fill_row_d;
  logic [COL_W-1:0]   fill_col_q, fill_col_d;
  logic [ROW_W-1:0]   cur_row_q, cur_row_d;
  logic [COL_W-1:0]   cur_col_q, cur_col_d;
  logic [ROW_W-1:0]   scroll_q, scroll_d;
  logic               wr_en_q, wr_en_d;
  logic [ADR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DAT_W-1:0]   wr_data_q, wr_data_d;
  logic               ready_q, ready_d;
  logic               busy_q;
  logic               accept_c;
  logic               do_lf;
`ifdef CONSOLE_TAB_EN
  logic [TAB_W-1:0]   tab_col;
`endif

  // Logical row to physical buffer row, wrapping once at ROWS.
  function automatic logic [ROW_W-1:0] phys_of(input logic [ROW_W-1:0] row,
                                                input logic [ROW_W-1:0] scr);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(row) + SUM_W'(scr);
    if (sum >= SUM_W'(ROWS)) sum = sum - SUM_W'(ROWS);
    return sum[ROW_W-1:0];
  endfunction

  assign accept_c = con_if.key_valid && ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLR_ALL;
      fill_row_q <= '0;
      fill_col_q <= '0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      scroll_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      fill_row_q <= fill_row_d;
      fill_col_q <= fill_col_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      scroll_q   <= scroll_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ready_q    <= ready_d;
      busy_q     <= !ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_row_d = fill_row_q;
    fill_col_d = fill_col_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    scroll_d   = scroll_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    do_lf      = 1'b0;
`ifdef CONSOLE_TAB_EN
    tab_col    = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (con_if.key_data >= 8'h20 && con_if.key_data != 8'h7F) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {phys_of(cur_row_q, scroll_q), cur_col_q};
            wr_data_d = {con_if.key_color, con_if.key_data};
            if (cur_col_q == COL_W'(COLS - 1)) begin
              cur_col_d = '0;
              do_lf     = 1'b1;
            end else begin
              cur_col_d = cur_col_q + COL_W'(1);
            end
          end else begin
            case (con_if.key_data)
              8'h0A: begin
                cur_col_d = '0;
                do_lf     = 1'b1;
              end
              8'h0D: cur_col_d = '0;
              8'h08: begin
                if (cur_col_q != '0) begin
                  cur_col_d = cur_col_q - COL_W'(1);
                  wr_en_d   = 1'b1;
                  wr_addr_d = {phys_of(cur_row_q, scroll_q), cur_col_q - COL_W'(1)};
                  wr_data_d = {CLR_W'(0), BLANK};
                end else if (cur_row_q != '0) begin
                  cur_row_d = cur_row_q - ROW_W'(1);
                  cur_col_d = COL_W'(COLS - 1);
                  wr_en_d   = 1'b1;
                  wr_addr_d = {phys_of(cur_row_q - ROW_W'(1), scroll_q), COL_W'(COLS - 1)};
                  wr_data_d = {CLR_W'(0), BLANK};
                end
              end
              8'h0C: begin
                cur_row_d  = '0;
                cur_col_d  = '0;
                scroll_d   = '0;
                fill_row_d = '0;
                fill_col_d = '0;
                state_d    = CLR_ALL;
              end
`ifdef CONSOLE_TAB_EN
              8'h09: begin
                tab_col = {1'b0, cur_col_q | COL_W'(7)} + TAB_W'(1);
                if (tab_col >= TAB_W'(COLS)) begin
                  cur_col_d = '0;
                  do_lf     = 1'b1;
                end else begin
                  cur_col_d = tab_col[COL_W-1:0];
                end
              end
`endif
              default: ;
            endcase
          end

          // Line feed at the bottom scrolls; the old top physical row becomes the new bottom line.
          if (do_lf) begin
            if (cur_row_q < ROW_W'(ROWS - 1)) begin
              cur_row_d = cur_row_q + ROW_W'(1);
            end else begin
              scroll_d   = (scroll_q == ROW_W'(ROWS - 1)) ? '0 : scroll_q + ROW_W'(1);
              fill_row_d = scroll_q;
              fill_col_d = '0;
              state_d    = CLR_LINE;
            end
          end
        end
      end

      CLR_LINE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {fill_row_q, fill_col_q};
        wr_data_d = {CLR_W'(0), BLANK};
        if (fill_col_q == COL_W'(COLS - 1)) begin
          state_d = IDLE;
        end else begin
          fill_col_d = fill_col_q + COL_W'(1);
        end
      end

      CLR_ALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {fill_row_q, fill_col_q};
        wr_data_d = {CLR_W'(0), BLANK};
        if (fill_col_q == COL_W'(COLS - 1)) begin
          fill_col_d = '0;
          if (fill_row_q == ROW_W'(ROWS - 1)) begin
            state_d = IDLE;
          end else begin
            fill_row_d = fill_row_q + ROW_W'(1);
          end
        end else begin
          fill_col_d = fill_col_q + COL_W'(1);
        end
      end

      default: state_d = CLR_ALL;
    endcase

    // Ready only once IDLE has been held for a full cycle, so it rises after the last fill write.
    ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  assign con_if.key_ready  = ready_q;
  assign con_if.busy       = busy_q;
  assign con_if.wr_en      = wr_en_q;
  assign con_if.wr_addr    = wr_addr_q;
  assign con_if.wr_data    = wr_data_q;
  assign con_if.scroll_row = scroll_q;
  assign con_if.cur_row    = cur_row_q;
  assign con_if.cur_col    = cur_col_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Randomized and directed bench for text_console_writer against a cursor/screen reference model.
module tb_text_console_writer;

  localparam int COLS = 70;
  localparam int ROWS = 30;
  localparam logic [7:0] BLANK = 8'h20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_console_if con_if();

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk    (clk),
    .reset  (reset),
    .con_if (con_if)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int unsigned last_acc_cyc = 0;

  int m_row, m_col, m_scroll;
  logic [22:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] wr_word(input int prow, input int col,
                                          input logic [2:0] c, input logic [7:0] d);
    return {5'(prow), 7'(col), c, d};
  endfunction

  task automatic push_fill_row(input int prow);
    for (int col = 0; col < COLS; col++) exp_q.push_back(wr_word(prow, col, 3'd0, BLANK));
  endtask

  task automatic push_fill_all();
    for (int r = 0; r < ROWS; r++) push_fill_row(r);
  endtask

  // Reference behaviour of one accepted key; returns how many cycles key_ready should stay low.
  task automatic model_key(input logic [7:0] d, input logic [2:0] c, output int busy);
    bit lf;
    int t;
    busy = 0;
    lf   = 0;
    if (d >= 8'h20 && d != 8'h7F) begin
      exp_q.push_back(wr_word((m_row + m_scroll) % ROWS, m_col, c, d));
      if (m_col == COLS - 1) begin m_col = 0; lf = 1; end
      else m_col++;
    end else if (d == 8'h0A) begin
      m_col = 0; lf = 1;
    end else if (d == 8'h0D) begin
      m_col = 0;
    end else if (d == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_q.push_back(wr_word((m_row + m_scroll) % ROWS, m_col, 3'd0, BLANK));
      end else if (m_row > 0) begin
        m_row--;
        m_col = COLS - 1;
        exp_q.push_back(wr_word((m_row + m_scroll) % ROWS, m_col, 3'd0, BLANK));
      end
    end else if (d == 8'h0C) begin
      m_row = 0; m_col = 0; m_scroll = 0;
      push_fill_all();
      busy = ROWS * COLS + 1;
    end
`ifdef CONSOLE_TAB_EN
    else if (d == 8'h09) begin
      t = (m_col | 7) + 1;
      if (t >= COLS) begin m_col = 0; lf = 1; end
      else m_col = t;
    end
`endif
    if (lf) begin
      if (m_row < ROWS - 1) m_row++;
      else begin
        push_fill_row(m_scroll);
        m_scroll = (m_scroll + 1) % ROWS;
        busy = COLS + 1;
      end
    end
  endtask

  // Write monitor and ready/busy complement check, sampled away from the active edge.
  always @(negedge clk) begin
    logic [22:0] w;
    if (!reset) begin
      check_eq("busy_vs_ready", con_if.busy, !con_if.key_ready);
      if (con_if.wr_en) begin
        check_eq("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check_eq("wr_addr", con_if.wr_addr, w[22:11]);
          check_eq("wr_data", con_if.wr_data, w[10:0]);
        end
      end
    end
  end

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (!con_if.key_ready && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!con_if.key_ready) check_eq("ready_timeout", con_if.key_ready, 1);
  endtask

  task automatic check_cursor(input string tag);
    check_eq({tag, "_row"}, con_if.cur_row, m_row);
    check_eq({tag, "_col"}, con_if.cur_col, m_col);
    check_eq({tag, "_scroll"}, con_if.scroll_row, m_scroll);
  endtask

  task automatic send_key(input logic [7:0] d, input logic [2:0] c, input bit wait_busy = 1);
    int n;
    int busy;
    int low;
    bit acc;
    acc = 0;
    n   = 0;
    while (!acc && n < 3000) begin
      @(negedge clk);
      con_if.key_valid = 1'b1;
      con_if.key_data  = d;
      con_if.key_color = c;
      acc = con_if.key_ready;
      n++;
    end
    if (!acc) begin
      check_eq("accept_timeout", con_if.key_ready, 1);
      con_if.key_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last_acc_cyc = cyc;
    #1;
    model_key(d, c, busy);
    check_cursor("cursor");
    if (busy > 0 && wait_busy) begin
      @(negedge clk);
      con_if.key_valid = 1'b0;
      low = 0;
      while (!con_if.key_ready && low < busy + 10) begin
        low++;
        @(negedge clk);
      end
      check_eq("busy_cycles", low, busy);
    end
  endtask

  task automatic release_bus();
    @(negedge clk);
    con_if.key_valid = 1'b0;
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55)      return 8'($urandom_range(32'h20, 32'h7E));
    else if (r < 66) return 8'h0A;
    else if (r < 72) return 8'h0D;
    else if (r < 82) return 8'h08;
    else if (r < 86) return 8'h7F;
    else if (r < 90) return 8'($urandom_range(0, 31));
    else if (r < 95) return 8'h09;
    else if (r < 98) return 8'($urandom_range(32'h80, 32'hFF));
    else             return 8'h0C;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int unsigned a_cyc;
    reset            = 1'b1;
    con_if.key_valid = 1'b0;
    con_if.key_data  = 8'h00;
    con_if.key_color = 3'd0;
    m_row = 0; m_col = 0; m_scroll = 0;

    #12;
    check_eq("rst_wr_en", con_if.wr_en, 0);
    check_eq("rst_wr_addr", con_if.wr_addr, 0);
    check_eq("rst_wr_data", con_if.wr_data, 0);
    check_eq("rst_ready", con_if.key_ready, 0);
    check_eq("rst_busy", con_if.busy, 1);
    check_cursor("rst");

    @(negedge clk);
    reset = 1'b0;
    push_fill_all();
    wait_ready(3000, n);
    check_eq("clr_all_cycles", n, ROWS * COLS + 1);
    check_eq("clr_all_left", exp_q.size(), 0);
    check_cursor("post_clear");

    // Back-to-back printable keys.
    send_key(8'h41, 3'd1);
    a_cyc = last_acc_cyc;
    send_key(8'h42, 3'd1);
    check_eq("back_to_back", last_acc_cyc - a_cyc, 1);
    check_eq("ab_col", con_if.cur_col, 2);

    // Fill the bottom line so the 70th key wraps and scrolls.
    send_key(8'h0D, 3'd0);
    for (int i = 0; i < ROWS - 1; i++) send_key(8'h0A, 3'd0);
    for (int i = 0; i < COLS; i++) send_key(8'(8'h41 + i % 26), 3'($urandom_range(0, 7)));
    check_eq("wrap_scroll", con_if.scroll_row, 1);
    check_eq("wrap_row", con_if.cur_row, ROWS - 1);
    check_eq("wrap_col", con_if.cur_col, 0);

    // Backspace across a line boundary with a nonzero scroll.
    send_key(8'h08, 3'd5);
    send_key(8'h0A, 3'd0);
    for (int i = 0; i < 4; i++) send_key(8'h0A, 3'd0);
    check_eq("scroll5", con_if.scroll_row, 5);

    send_key(8'h0C, 3'd2);
    check_eq("ff_scroll", con_if.scroll_row, 0);
    for (int i = 0; i < 3; i++) send_key(8'h0A, 3'd0);
    send_key(8'h08, 3'd0);
    check_eq("bs_row", con_if.cur_row, 2);
    check_eq("bs_col", con_if.cur_col, COLS - 1);
    send_key(8'h0D, 3'd0); send_key(8'h08, 3'd0);
    send_key(8'h0D, 3'd0); send_key(8'h08, 3'd0);
    send_key(8'h0D, 3'd0); send_key(8'h08, 3'd0);
    check_eq("bs_home_row", con_if.cur_row, 0);
    check_eq("bs_home_col", con_if.cur_col, 0);
    release_bus();
    repeat (3) @(negedge clk);
    check_eq("bs_home_nowrite", exp_q.size(), 0);

    // Tab handling.
    for (int i = 0; i < 3; i++) send_key(8'h61, 3'd3);
    send_key(8'h09, 3'd0);
`ifdef CONSOLE_TAB_EN
    check_eq("tab_from3", con_if.cur_col, 8);
`else
    check_eq("tab_from3", con_if.cur_col, 3);
`endif
    send_key(8'h0D, 3'd0);
    for (int i = 0; i < 67; i++) send_key(8'h62, 3'd4);
    send_key(8'h09, 3'd0);
`ifdef CONSOLE_TAB_EN
    check_eq("tab_from67", con_if.cur_col, 0);
`else
    check_eq("tab_from67", con_if.cur_col, 67);
`endif

    // Reset in the middle of a full clear.
    send_key(8'h0C, 3'd0, 1'b0);
    release_bus();
    repeat (400) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort_wr_en", con_if.wr_en, 0);
    check_eq("abort_ready", con_if.key_ready, 0);
    exp_q.delete();
    m_row = 0; m_col = 0; m_scroll = 0;
    check_cursor("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_fill_all();
    wait_ready(3000, n);
    check_eq("restart_cycles", n, ROWS * COLS + 1);

    // Random key stream.
    repeat (300) send_key(rand_key(), 3'($urandom_range(0, 7)));
    release_bus();
    wait_ready(3000, n);
    repeat (3) @(negedge clk);
    check_eq("final_queue", exp_q.size(), 0);
    check_cursor("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
